// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, line levels and parity helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Widest data word the parity helper accepts; narrower words are zero-extended.
    localparam int PARITY_MAX_W = 64;

    function automatic logic parity_bit(input logic [PARITY_MAX_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Transmitter handshake bundle: start/busy/done request side plus serial line and debug state.
// Handshake: a request is taken on any clk edge where tx_start=1 and the block is idle
// (tx_busy=0); requests while busy are dropped, and tx_done pulses once per finished frame.
interface uart_tx_if #(
    parameter int SIZE = 8
);
    import uart_pkg::*;

    logic            tx_start;
    logic [SIZE-1:0] data_in;
    logic            tx;
    logic            tx_busy;
    logic            tx_done;
    state_t          dbg_state;

    modport master (
        output tx_start,
        output data_in,
        input  tx,
        input  tx_busy,
        input  tx_done,
        input  dbg_state
    );

    modport slave (
        input  tx_start,
        input  data_in,
        output tx,
        output tx_busy,
        output tx_done,
        output dbg_state
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..BAUD_COUNT-1 while enabled and flags the last cycle of each bit.
// Holding i_clear keeps the counter at zero so the next bit starts a full period.
module uart_baud_tick #(
    parameter int BAUD_COUNT = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int                CNT_W = (BAUD_COUNT > 1) ? $clog2(BAUD_COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BAUD_COUNT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, SIZE data bits LSB first, optional parity, one stop bit.
// All outputs are registered so the line only moves on bit boundaries, accept, or reset.
module uart_tx
    import uart_pkg::*;
#(
    parameter int SIZE       = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_COUNT = 9,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic    clk,
    input  logic    rst,
    uart_tx_if.slave bus
);

    localparam int               BIT_W    = $clog2(SIZE + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SIZE - 1);

    if (BAUD_COUNT < 2 || SIZE < 1 || SIZE > PARITY_MAX_W || BAUD_RATE <= 0 || CLK_FREQ <= 0)
    begin : g_bad_param
        $error("uart_tx: illegal parameter set");
    end

    state_t           r_state, w_state;
    logic             r_tx, w_tx;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic             r_parity, w_parity;
    logic [SIZE-1:0]  r_shift, w_shift;
    logic [BIT_W-1:0] r_bit_cnt, w_bit_cnt;

    logic                    w_tick;
    logic                    w_baud_clear;
    logic [PARITY_MAX_W-1:0] w_par_in;

    // The bit timer idles at zero so the start bit gets a full period after accept.
    assign w_baud_clear = (r_state == IDLE);

    uart_baud_tick #(
        .BAUD_COUNT(BAUD_COUNT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .i_clear(w_baud_clear),
        .o_tick (w_tick)
    );

    always_comb begin
        w_par_in             = '0;
        w_par_in[SIZE-1:0]   = bus.data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tx      <= STOP_BIT;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_parity  <= 1'b0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state;
            r_tx      <= w_tx;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_parity  <= w_parity;
            r_shift   <= w_shift;
            r_bit_cnt <= w_bit_cnt;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_tx      = r_tx;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_parity  = r_parity;
        w_shift   = r_shift;
        w_bit_cnt = r_bit_cnt;

        case (r_state)
            IDLE: begin
                w_tx = STOP_BIT;
                if (bus.tx_start) begin
                    w_shift  = bus.data_in;
                    w_parity = parity_bit(w_par_in, PARITY_ODD != 0);
                    w_tx     = START_BIT;
                    w_busy   = 1'b1;
                    w_state  = TX_START;
                end
            end
            TX_START: begin
                if (w_tick) begin
                    w_tx      = r_shift[0];
                    w_shift   = r_shift >> 1;
                    w_bit_cnt = '0;
                    w_state   = TX_DATA;
                end
            end
            TX_DATA: begin
                if (w_tick) begin
                    w_bit_cnt = r_bit_cnt + BIT_W'(1);
                    if (r_bit_cnt == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            w_tx    = r_parity;
                            w_state = TX_PARITY;
                        end else begin
                            w_tx    = STOP_BIT;
                            w_state = TX_STOP;
                        end
                    end else begin
                        w_tx    = r_shift[0];
                        w_shift = r_shift >> 1;
                    end
                end
            end
            TX_PARITY: begin
                if (w_tick) begin
                    w_tx    = STOP_BIT;
                    w_state = TX_STOP;
                end
            end
            TX_STOP: begin
                if (w_tick) begin
                    w_state = IDLE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end
            end
            default: begin
                w_state = IDLE;
                w_tx    = STOP_BIT;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign bus.tx        = r_tx;
    assign bus.tx_busy   = r_busy;
    assign bus.tx_done   = r_done;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default, even/odd parity and BAUD_COUNT=2 variants share stimulus;
// one instance at a time is selected for checking.
module tb_uart_tx;
    import uart_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data;
    int         sel;

    int n_checks;
    int n_pass;

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_if #(.SIZE(8)) bus0  ();
    uart_tx_if #(.SIZE(8)) bus_pe();
    uart_tx_if #(.SIZE(8)) bus_po();
    uart_tx_if #(.SIZE(8)) bus_b2();

    assign bus0.tx_start   = start;
    assign bus0.data_in    = data;
    assign bus_pe.tx_start = start;
    assign bus_pe.data_in  = data;
    assign bus_po.tx_start = start;
    assign bus_po.data_in  = data;
    assign bus_b2.tx_start = start;
    assign bus_b2.data_in  = data;

    uart_tx #(.SIZE(8), .BAUD_COUNT(9), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    uart_tx #(.SIZE(8), .BAUD_COUNT(9), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
        .clk(clk), .rst(rst), .bus(bus_pe));
    uart_tx #(.SIZE(8), .BAUD_COUNT(9), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
        .clk(clk), .rst(rst), .bus(bus_po));
    uart_tx #(.SIZE(8), .BAUD_COUNT(2), .PARITY_EN(0), .PARITY_ODD(0)) dut_b2 (
        .clk(clk), .rst(rst), .bus(bus_b2));

    logic   m_tx, m_busy, m_done;
    state_t m_state;

    always_comb begin
        m_tx    = bus0.tx;
        m_busy  = bus0.tx_busy;
        m_done  = bus0.tx_done;
        m_state = bus0.dbg_state;
        case (sel)
            1: begin
                m_tx = bus_pe.tx; m_busy = bus_pe.tx_busy;
                m_done = bus_pe.tx_done; m_state = bus_pe.dbg_state;
            end
            2: begin
                m_tx = bus_po.tx; m_busy = bus_po.tx_busy;
                m_done = bus_po.tx_done; m_state = bus_po.dbg_state;
            end
            3: begin
                m_tx = bus_b2.tx; m_busy = bus_b2.tx_busy;
                m_done = bus_b2.tx_done; m_state = bus_b2.dbg_state;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    // Pulse tx_start for one accept edge; returns at the negedge right after accept.
    task automatic send(input logic [7:0] d);
        @(negedge clk);
        start = 1'b1;
        data  = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Scoreboard: expected line levels per bit; each bit held for `baud` cycles.
    // Called at the first negedge after accept, returns at the negedge after the done edge.
    task automatic check_frame(input logic [7:0] d, input bit par_en, input logic par_bit,
                               input int baud, input string tag);
        logic exp_q[$];
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (par_en) exp_q.push_back(par_bit);
        exp_q.push_back(1'b1);
        for (int k = 0; k < exp_q.size(); k++) begin
            for (int j = 0; j < baud; j++) begin
                chk({tag, "_tx"},   m_tx,   exp_q[k]);
                chk({tag, "_busy"}, m_busy, 1);
                chk({tag, "_done"}, m_done, 0);
                @(negedge clk);
            end
        end
        chk({tag, "_done_pulse"}, m_done, 1);
        chk({tag, "_busy_end"},   m_busy, 0);
        chk({tag, "_tx_end"},     m_tx,   1);
        chk({tag, "_state_end"},  m_state, IDLE);
    endtask

    task automatic check_idle(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            chk({tag, "_tx"},   m_tx,   1);
            chk({tag, "_busy"}, m_busy, 0);
            chk({tag, "_done"}, m_done, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        sel      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        data     = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx",    m_tx,    1);
        chk("rst_busy",  m_busy,  0);
        chk("rst_done",  m_done,  0);
        chk("rst_state", m_state, IDLE);
        rst = 1'b0;
        check_idle(3, "post_rst");

        // single frame 0xA5
        send(8'hA5);
        check_frame(8'hA5, 0, 1'b0, 9, "a5");
        @(negedge clk);
        chk("a5_done_one_cycle", m_done, 0);

        // back-to-back with tx_start held: line high 10 cycles between frames
        pulse_reset();
        @(negedge clk);
        start = 1'b1;
        data  = 8'h00;
        @(negedge clk);
        data  = 8'hFF;
        check_frame(8'h00, 0, 1'b0, 9, "b2b0");
        @(negedge clk);
        start = 1'b0;
        chk("b2b_restart_tx",   m_tx,   0);
        chk("b2b_restart_busy", m_busy, 1);
        chk("b2b_restart_done", m_done, 0);
        check_frame(8'hFF, 0, 1'b0, 9, "b2b1");
        @(negedge clk);
        check_idle(12, "b2b_after");

        // data_in changes and tx_start while busy are ignored
        send(8'h81);
        fork
            check_frame(8'h81, 0, 1'b0, 9, "hold81");
            begin
                repeat (5) @(negedge clk);
                data = 8'h3C;
                repeat (35) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        @(negedge clk);
        check_idle(20, "hold_idle");
        send(8'h3C);
        check_frame(8'h3C, 0, 1'b0, 9, "f3c");
        @(negedge clk);

        // reset mid-frame abandons it without tx_done
        send(8'h5A);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_tx",    m_tx,    1);
        chk("midrst_busy",  m_busy,  0);
        chk("midrst_done",  m_done,  0);
        chk("midrst_state", m_state, IDLE);
        check_idle(100, "midrst_idle");
        send(8'hC3);
        check_frame(8'hC3, 0, 1'b0, 9, "fc3");

        // even parity: 0x07 has three ones -> parity 1, 99-cycle frame
        sel = 1;
        pulse_reset();
        send(8'h07);
        check_frame(8'h07, 1, 1'b1, 9, "par_even");

        // odd parity: parity 0
        sel = 2;
        pulse_reset();
        send(8'h07);
        check_frame(8'h07, 1, 1'b0, 9, "par_odd");

        // even parity on a word with even popcount -> parity 0
        sel = 1;
        pulse_reset();
        send(8'h81);
        check_frame(8'h81, 1, 1'b0, 9, "par_even81");

        // shortest legal bit period
        sel = 3;
        pulse_reset();
        send(8'h55);
        check_frame(8'h55, 0, 1'b0, 2, "baud2");
        @(negedge clk);
        check_idle(4, "baud2_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
